// File: rtl/btn_debounce_event.sv
// btn_debounce_event: synchronizes and debounces a push-button, emitting press/release/long-hold events and a press count
module btn_debounce_event #(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int LONG_CYCLES     = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {IDLE, QUAL_PRESS, HELD, QUAL_RELEASE} state_t;

    localparam logic [15:0] QLAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HLAST = 16'(LONG_CYCLES - 1);

    state_t      state, state_n;
    logic        sync1, btn_s;
    logic [15:0] qcnt, qcnt_n, hcnt, hcnt_n;
    logic        long_done, long_done_n;
    logic        level_n, press_n, release_n, long_n;
    logic [7:0]  count_n;

    // two-flop synchronizer; only btn_s is used downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            qcnt          <= '0;
            hcnt          <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_n;
            qcnt          <= qcnt_n;
            hcnt          <= hcnt_n;
            long_done     <= long_done_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
            press_count   <= count_n;
        end
    end

    // next-state logic; the hold counter pauses during release qualification so a bounce does not restart long-press timing
    always_comb begin
        state_n     = state;
        qcnt_n      = qcnt;
        hcnt_n      = hcnt;
        long_done_n = long_done;
        level_n     = btn_level;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        count_n     = press_count;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = QUAL_PRESS;
                    qcnt_n  = 16'd1;
                end
            end
            QUAL_PRESS: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    qcnt_n  = '0;
                end else if (qcnt == QLAST) begin
                    state_n = HELD;
                    qcnt_n  = '0;
                    hcnt_n  = '0;
                    level_n = 1'b1;
                    press_n = 1'b1;
                    count_n = press_count + 8'd1;
                end else begin
                    qcnt_n = qcnt + 16'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_n = QUAL_RELEASE;
                    qcnt_n  = 16'd1;
                end else if (!long_done) begin
                    if (hcnt == HLAST) begin
                        long_n      = 1'b1;
                        long_done_n = 1'b1;
                    end else begin
                        hcnt_n = hcnt + 16'd1;
                    end
                end
            end
            QUAL_RELEASE: begin
                if (btn_s) begin
                    state_n = HELD;
                    qcnt_n  = '0;
                end else if (qcnt == QLAST) begin
                    state_n     = IDLE;
                    qcnt_n      = '0;
                    hcnt_n      = '0;
                    long_done_n = 1'b0;
                    level_n     = 1'b0;
                    release_n   = 1'b1;
                end else begin
                    qcnt_n = qcnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_btn_debounce_event.sv
// tb_btn_debounce_event: randomized and directed checks of btn_debounce_event against a run-length reference model
module tb_btn_debounce_event;
    localparam int D    = 8;
    localparam int LONG = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b1;
    logic       btn_level, press_pulse, release_pulse, long_pulse;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;

    logic       ms1, ms2, e_level, e_press, e_rel, e_long, held_done;
    logic [7:0] e_count;
    int         run, held;
    int         n_press, n_rel, n_long;

    btn_debounce_event #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(LONG)) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms1 = 0; ms2 = 0; e_level = 0; e_press = 0; e_rel = 0; e_long = 0;
        held_done = 0; e_count = 0; run = 0; held = 0;
    endtask

    // A level change is accepted after D consecutive synchronized samples that differ from the current level;
    // the long event fires on the LONG-th stable-pressed sample after the press was accepted.
    task automatic model_edge();
        logic smp;
        smp = ms2; ms2 = ms1; ms1 = btn;
        e_press = 0; e_rel = 0; e_long = 0;
        if (e_level && run == 0 && smp && !held_done) begin
            held++;
            if (held == LONG) begin e_long = 1; held_done = 1; end
        end
        run = (smp != e_level) ? run + 1 : 0;
        if (run == D) begin
            run = 0; held = 0; held_done = 0;
            e_level = !e_level;
            if (e_level) begin e_press = 1; e_count++; end
            else e_rel = 1;
        end
    endtask

    task automatic check_outputs();
        chk("btn_level", int'(btn_level), int'(e_level));
        chk("press_pulse", int'(press_pulse), int'(e_press));
        chk("release_pulse", int'(release_pulse), int'(e_rel));
        chk("long_pulse", int'(long_pulse), int'(e_long));
        chk("press_count", int'(press_count), int'(e_count));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check_outputs();
        n_press += int'(press_pulse);
        n_rel   += int'(release_pulse);
        n_long  += int'(long_pulse);
    endtask

    task automatic run_for(input int n);
        repeat (n) step();
    endtask

    task automatic clear_tally();
        n_press = 0; n_rel = 0; n_long = 0;
    endtask

    task automatic async_reset(input int hold_cycles);
        #3 reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_level", int'(btn_level), 0);
        chk("async_rst_count", int'(press_count), 0);
        chk("async_rst_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
        run_for(hold_cycles);
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0] start_cnt;
        model_reset();
        clear_tally();
        // reset held with the button pressed: everything stays low
        run_for(10);
        reset = 1'b0;
        lat = 0;
        while (!btn_level && lat < 3 * D) begin
            step();
            lat++;
        end
        chk("press_latency", lat, D + 2);
        chk("first_press_count", int'(press_count), 1);
        btn = 1'b0;
        run_for(D + 5);

        // short high glitches never qualify
        clear_tally();
        for (int i = 0; i < 20; i++) begin
            btn = 1'b1;
            run_for($urandom_range(1, D - 1));
            btn = 1'b0;
            run_for($urandom_range(1, 2 * D));
        end
        chk("glitch_presses", n_press, 0);
        chk("glitch_level", int'(btn_level), 0);

        // clean long press: one press, one long, one release
        clear_tally();
        btn = 1'b1;
        run_for(LONG + D + 20);
        btn = 1'b0;
        run_for(D + 10);
        chk("clean_presses", n_press, 1);
        chk("clean_longs", n_long, 1);
        chk("clean_releases", n_rel, 1);

        // low glitch inside HELD pauses long timing without releasing
        clear_tally();
        btn = 1'b1;
        run_for(D + LONG / 2);
        btn = 1'b0;
        run_for(D / 2 + 1);
        btn = 1'b1;
        run_for(LONG);
        chk("held_glitch_releases", n_rel, 0);
        chk("held_glitch_level", int'(btn_level), 1);
        chk("held_glitch_longs", n_long, 1);
        btn = 1'b0;
        run_for(D + 5);

        // reset mid-press discards it; requalification needed afterwards
        btn = 1'b1;
        run_for(D + 10);
        async_reset(3);
        lat = 0;
        while (!btn_level && lat < 3 * D) begin
            step();
            lat++;
        end
        chk("requal_latency", lat, D + 2);
        btn = 1'b0;
        run_for(D + 5);

        // 256 short presses wrap the counter back to its start value
        clear_tally();
        start_cnt = e_count;
        for (int i = 0; i < 256; i++) begin
            btn = 1'b1;
            run_for(D + 3 + $urandom_range(0, 3));
            btn = 1'b0;
            run_for(D + 3 + $urandom_range(0, 3));
        end
        chk("wrap_count", int'(press_count), int'(start_cnt));
        chk("wrap_presses", n_press, 256);
        chk("wrap_longs", n_long, 0);

        // random bouncing
        for (int i = 0; i < 60; i++) begin
            btn = 1'($urandom_range(0, 1));
            run_for($urandom_range(1, 2 * D + LONG / 4));
        end
        btn = 1'b0;
        run_for(2 * D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
